// File: rtl/lsu_mem_port.sv
// Load/store unit between the MIPS memory stage and a handshaked data memory.
// Builds byte-lane enables, replicates store data across lanes, extracts and
// extends load data, stalls the pipeline while an access is in flight and
// reports misaligned, illegal-size and timed-out accesses as exceptions.
module lsu_mem_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [4:0]            req_tag,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [4:0]            rsp_tag,
  output logic                  exc_valid,
  output logic [1:0]            exc_code,
  output logic [ADDR_W-1:0]     exc_badaddr
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'd0;
  localparam logic [1:0] EXC_STORE_MISALIGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT        = 2'd2;
  localparam logic [1:0] EXC_ILLEGAL_SIZE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Lowest byte lane occupied by an access of 2**size bytes at offset off.
  function automatic logic [OFF_W-1:0] lane_lo(input logic [1:0]       size,
                                               input logic [OFF_W-1:0] off);
    int lo;
    if (BIG_ENDIAN) lo = NB - int'(off) - (1 << size);
    else            lo = int'(off);
    return OFF_W'(lo);
  endfunction

  // Contiguous run of 2**size enables starting at lane lo.
  function automatic logic [NB-1:0] lane_mask(input logic [1:0]       size,
                                              input logic [OFF_W-1:0] lo);
    logic [NB-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(lo) && i < int'(lo) + (1 << size)) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Copy the low 2**size bytes of the store data into every slot of that size.
  // Because accesses are aligned, slot byte k always lands in the lane that
  // carries byte k of the value, for either endianness.
  function automatic logic [DATA_W-1:0] replicate(input logic [1:0]        size,
                                                  input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[i*8 +: 8] = wdata[(i % (1 << size))*8 +: 8];
    end
    return r;
  endfunction

  // Right-justify the selected lanes and sign- or zero-extend to DATA_W.
  function automatic logic [DATA_W-1:0] extract(input logic [1:0]        size,
                                                input logic              uns,
                                                input logic [OFF_W-1:0]  lo,
                                                input logic [DATA_W-1:0] rdata);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] r;
    logic              sign;
    int                nbits;
    sh    = rdata >> (int'(lo) * 8);
    nbits = 8 << size;
    if (nbits > DATA_W) nbits = DATA_W;
    sign  = ~uns & sh[nbits-1];
    for (int b = 0; b < DATA_W; b++) begin
      r[b] = (b < nbits) ? sh[b] : sign;
    end
    return r;
  endfunction

  // Architectural state
  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [OFF_W-1:0]    lo_q;
  logic [4:0]          tag_q;
  logic [ADDR_W-1:0]   addr_q;

  // Registered outputs
  logic                req_ready_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [NB-1:0]       mem_be_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [4:0]          rsp_tag_q;
  logic                exc_valid_q;
  logic [1:0]          exc_code_q;
  logic [ADDR_W-1:0]   exc_badaddr_q;

  // Request decode
  logic                illegal_size;
  logic                misaligned;
  logic                legal_req;
  logic [OFF_W-1:0]    lo_d;
  logic [NB-1:0]       be_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   load_data_d;
  logic [CNT_W-1:0]    cnt_d;

  assign illegal_size = (req_size == 2'd3) && (DATA_W == 32);
  assign misaligned   = ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                     || ((req_size == 2'd3) && (req_addr[2:0] != 3'b000));
  assign legal_req    = ~illegal_size & ~misaligned;

  assign lo_d        = lane_lo(req_size, req_addr[OFF_W-1:0]);
  assign be_d        = lane_mask(req_size, lo_d);
  assign wdata_d     = replicate(req_size, req_wdata);
  assign addr_d      = req_addr & ~ADDR_W'(NB - 1);
  assign load_data_d = extract(size_q, unsigned_q, lo_q, mem_rdata);
  assign cnt_d       = cnt_q + 1'b1;

  // Stall in the accept cycle too, so the stage holds its operands; reset
  // forces the stall low with everything else.
  assign busy = ~rst && ((state_q != IDLE) || (req_valid && legal_req));

  // Access sequencer: accept, issue, wait for ack or timeout, respond.
  // NOTE: every register here uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
      lo_q          <= '0;
      tag_q         <= 5'd0;
      addr_q        <= '0;
      req_ready_q   <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_be_q      <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_tag_q     <= 5'd0;
      exc_valid_q   <= 1'b0;
      exc_code_q    <= 2'd0;
      exc_badaddr_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      exc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (illegal_size) begin
              exc_valid_q   <= 1'b1;
              exc_code_q    <= EXC_ILLEGAL_SIZE;
              exc_badaddr_q <= req_addr;
            end else if (misaligned) begin
              exc_valid_q   <= 1'b1;
              exc_code_q    <= req_we ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
              exc_badaddr_q <= req_addr;
            end else begin
              state_q     <= ACCESS;
              cnt_q       <= '0;
              we_q        <= req_we;
              size_q      <= req_size;
              unsigned_q  <= req_unsigned;
              lo_q        <= lo_d;
              tag_q       <= req_tag;
              addr_q      <= req_addr;
              req_ready_q <= 1'b0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we;
              mem_be_q    <= be_d;
              mem_addr_q  <= addr_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state_q     <= RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            rsp_valid_q <= 1'b1;
            rsp_tag_q   <= tag_q;
            rsp_rdata_q <= we_q ? '0 : load_data_d;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_be_q      <= '0;
            exc_valid_q   <= 1'b1;
            exc_code_q    <= EXC_TIMEOUT;
            exc_badaddr_q <= addr_q;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_be      = mem_be_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_tag     = rsp_tag_q;
  assign exc_valid   = exc_valid_q;
  assign exc_code    = exc_code_q;
  assign exc_badaddr = exc_badaddr_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port: a 32-bit big-endian instance with a short
// timeout and a 64-bit little-endian instance, driven by one linear sequence.
module tb_lsu_mem_port;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // 32-bit big-endian instance, TIMEOUT=4
  logic        a_req_valid, a_req_ready, a_req_we, a_req_unsigned, a_busy;
  logic        a_mem_req, a_mem_we, a_mem_ack, a_rsp_valid, a_exc_valid;
  logic [1:0]  a_req_size, a_exc_code;
  logic [31:0] a_req_addr, a_req_wdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [31:0] a_rsp_rdata, a_exc_badaddr;
  logic [3:0]  a_mem_be;
  logic [4:0]  a_req_tag, a_rsp_tag;

  // 64-bit little-endian instance, TIMEOUT=16
  logic        b_req_valid, b_req_ready, b_req_we, b_req_unsigned, b_busy;
  logic        b_mem_req, b_mem_we, b_mem_ack, b_rsp_valid, b_exc_valid;
  logic [1:0]  b_req_size, b_exc_code;
  logic [31:0] b_req_addr, b_mem_addr, b_exc_badaddr;
  logic [63:0] b_req_wdata, b_mem_wdata, b_mem_rdata, b_rsp_rdata;
  logic [7:0]  b_mem_be;
  logic [4:0]  b_req_tag, b_rsp_tag;

  lsu_mem_port #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_tag(a_req_tag), .busy(a_busy),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_tag(a_rsp_tag),
    .exc_valid(a_exc_valid), .exc_code(a_exc_code), .exc_badaddr(a_exc_badaddr)
  );

  lsu_mem_port #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_tag(b_req_tag), .busy(b_busy),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_tag(b_rsp_tag),
    .exc_valid(b_exc_valid), .exc_code(b_exc_code), .exc_badaddr(b_exc_badaddr)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] tag);
    a_req_valid    = 1'b1;
    a_req_we       = we;
    a_req_size     = size;
    a_req_unsigned = uns;
    a_req_addr     = addr;
    a_req_wdata    = wdata;
    a_req_tag      = tag;
  endtask

  task automatic issue_b(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata,
                         input logic [4:0] tag);
    b_req_valid    = 1'b1;
    b_req_we       = we;
    b_req_size     = size;
    b_req_unsigned = uns;
    b_req_addr     = addr;
    b_req_wdata    = wdata;
    b_req_tag      = tag;
  endtask

  // Load on instance a with an ack in the first access cycle.
  task automatic load_a(input string name, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue_a(1'b0, size, uns, addr, 32'h0, 5'd9);
    tick();
    a_req_valid = 1'b0;
    check({name, "_mem_req"}, 64'(a_mem_req), 64'(1'b1));
    check({name, "_be"}, 64'(a_mem_be), 64'(exp_be));
    a_mem_ack   = 1'b1;
    a_mem_rdata = rdata;
    tick();
    a_mem_ack   = 1'b0;
    check({name, "_rsp_valid"}, 64'(a_rsp_valid), 64'(1'b1));
    check({name, "_rdata"}, 64'(a_rsp_rdata), 64'(exp_data));
    check({name, "_tag"}, 64'(a_rsp_tag), 64'(5'd9));
    tick();
    check({name, "_ready"}, 64'(a_req_ready), 64'(1'b1));
  endtask

  // Load on instance b with an ack in the first access cycle.
  task automatic load_b(input string name, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [63:0] rdata,
                        input logic [7:0] exp_be, input logic [31:0] exp_addr,
                        input logic [63:0] exp_data);
    issue_b(1'b0, size, uns, addr, 64'h0, 5'd17);
    tick();
    b_req_valid = 1'b0;
    check({name, "_be"}, 64'(b_mem_be), 64'(exp_be));
    check({name, "_addr"}, 64'(b_mem_addr), 64'(exp_addr));
    b_mem_ack   = 1'b1;
    b_mem_rdata = rdata;
    tick();
    b_mem_ack   = 1'b0;
    check({name, "_rsp_valid"}, 64'(b_rsp_valid), 64'(1'b1));
    check({name, "_rdata"}, b_rsp_rdata, exp_data);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'd0; a_req_unsigned = 1'b0;
    a_req_addr = 32'h0; a_req_wdata = 32'h0; a_req_tag = 5'd0;
    a_mem_ack = 1'b0; a_mem_rdata = 32'h0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
    b_req_addr = 32'h0; b_req_wdata = 64'h0; b_req_tag = 5'd0;
    b_mem_ack = 1'b0; b_mem_rdata = 64'h0;

    // Reset state
    tick();
    tick();
    check("rst_ready", 64'(a_req_ready), 64'(1'b1));
    check("rst_busy", 64'(a_busy), 64'(1'b0));
    check("rst_mem_req", 64'(a_mem_req), 64'(1'b0));
    check("rst_rsp_valid", 64'(a_rsp_valid), 64'(1'b0));
    check("rst_exc_valid", 64'(a_exc_valid), 64'(1'b0));
    check("rst_b_ready", 64'(b_req_ready), 64'(1'b1));
    rst = 1'b0;
    tick();

    // sb 0x1003 on big-endian, ack three cycles after issue
    issue_a(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd5);
    #1;
    check("sb_busy_accept", 64'(a_busy), 64'(1'b1));
    tick();
    a_req_valid = 1'b0;
    check("sb_mem_req", 64'(a_mem_req), 64'(1'b1));
    check("sb_mem_we", 64'(a_mem_we), 64'(1'b1));
    check("sb_be", 64'(a_mem_be), 64'(4'b0001));
    check("sb_addr", 64'(a_mem_addr), 64'(32'h0000_1000));
    check("sb_wdata", 64'(a_mem_wdata), 64'(32'hABAB_ABAB));
    check("sb_ready", 64'(a_req_ready), 64'(1'b0));
    tick();
    check("sb_mem_req_hold", 64'(a_mem_req), 64'(1'b1));
    tick();
    a_mem_ack = 1'b1;
    check("sb_be_ack_cycle", 64'(a_mem_be), 64'(4'b0001));
    tick();
    a_mem_ack = 1'b0;
    check("sb_rsp_valid", 64'(a_rsp_valid), 64'(1'b1));
    check("sb_rsp_rdata", 64'(a_rsp_rdata), 64'(32'h0));
    check("sb_rsp_tag", 64'(a_rsp_tag), 64'(5'd5));
    check("sb_mem_req_drop", 64'(a_mem_req), 64'(1'b0));
    check("sb_busy_resp", 64'(a_busy), 64'(1'b1));
    tick();
    check("sb_rsp_pulse", 64'(a_rsp_valid), 64'(1'b0));
    check("sb_idle_busy", 64'(a_busy), 64'(1'b0));

    // Big-endian load extraction
    load_a("lb",  2'd0, 1'b0, 32'h0000_2000, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    load_a("lbu", 2'd0, 1'b1, 32'h0000_2001, 32'h80FF_1234, 4'b0100, 32'h0000_00FF);
    load_a("lh",  2'd1, 1'b0, 32'h0000_2002, 32'h80FF_1234, 4'b0011, 32'h0000_1234);
    load_a("lhu_hi", 2'd1, 1'b1, 32'h0000_2000, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);

    // Misaligned load and store
    issue_a(1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 5'd1);
    #1;
    check("lw_mis_busy", 64'(a_busy), 64'(1'b0));
    tick();
    a_req_valid = 1'b0;
    check("lw_mis_exc", 64'(a_exc_valid), 64'(1'b1));
    check("lw_mis_code", 64'(a_exc_code), 64'(2'd0));
    check("lw_mis_addr", 64'(a_exc_badaddr), 64'(32'h0000_3002));
    check("lw_mis_mem_req", 64'(a_mem_req), 64'(1'b0));
    check("lw_mis_ready", 64'(a_req_ready), 64'(1'b1));
    tick();
    check("lw_mis_pulse", 64'(a_exc_valid), 64'(1'b0));
    check("lw_mis_mem_req2", 64'(a_mem_req), 64'(1'b0));
    issue_a(1'b1, 2'd1, 1'b0, 32'h0000_3001, 32'h0000_BEEF, 5'd2);
    tick();
    a_req_valid = 1'b0;
    check("sh_mis_exc", 64'(a_exc_valid), 64'(1'b1));
    check("sh_mis_code", 64'(a_exc_code), 64'(2'd1));
    check("sh_mis_mem_req", 64'(a_mem_req), 64'(1'b0));
    tick();

    // Illegal size on the 32-bit instance
    issue_a(1'b0, 2'd3, 1'b0, 32'h0000_0040, 32'h0, 5'd3);
    tick();
    a_req_valid = 1'b0;
    check("sz3_exc", 64'(a_exc_valid), 64'(1'b1));
    check("sz3_code", 64'(a_exc_code), 64'(2'd3));
    check("sz3_mem_req", 64'(a_mem_req), 64'(1'b0));
    tick();

    // Timeout: four access cycles without ack
    issue_a(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'h1122_3344, 5'd7);
    tick();
    a_req_valid = 1'b0;
    check("sw_wdata", 64'(a_mem_wdata), 64'(32'h1122_3344));
    for (int i = 0; i < 4; i++) begin
      check("to_mem_req", 64'(a_mem_req), 64'(1'b1));
      check("to_busy", 64'(a_busy), 64'(1'b1));
      tick();
    end
    check("to_exc", 64'(a_exc_valid), 64'(1'b1));
    check("to_code", 64'(a_exc_code), 64'(2'd2));
    check("to_addr", 64'(a_exc_badaddr), 64'(32'h0000_4000));
    check("to_mem_req_drop", 64'(a_mem_req), 64'(1'b0));
    check("to_busy_drop", 64'(a_busy), 64'(1'b0));
    check("to_ready", 64'(a_req_ready), 64'(1'b1));
    check("to_rsp_valid", 64'(a_rsp_valid), 64'(1'b0));
    load_a("lw_after_to", 2'd2, 1'b0, 32'h0000_2000, 32'h80FF_1234, 4'b1111, 32'h80FF_1234);

    // 64-bit little-endian instance
    load_b("ld", 2'd3, 1'b0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF,
           32'h0000_0008, 64'h0123_4567_89AB_CDEF);
    load_b("lw64", 2'd2, 1'b0, 32'h0000_000C, 64'h89AB_CDEF_0000_0000, 8'hF0,
           32'h0000_0008, 64'hFFFF_FFFF_89AB_CDEF);
    load_b("lbu64", 2'd0, 1'b1, 32'h0000_0011, 64'h0000_0000_0000_9A00, 8'h02,
           32'h0000_0010, 64'h0000_0000_0000_009A);
    issue_b(1'b1, 2'd1, 1'b0, 32'h0000_000A, 64'h0000_0000_0000_BEEF, 5'd4);
    tick();
    b_req_valid = 1'b0;
    check("sh64_be", 64'(b_mem_be), 64'(8'h0C));
    check("sh64_wdata", b_mem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    b_mem_ack = 1'b1;
    tick();
    b_mem_ack = 1'b0;
    check("sh64_rsp_valid", 64'(b_rsp_valid), 64'(1'b1));
    check("sh64_rsp_rdata", b_rsp_rdata, 64'h0);
    tick();

    // Reset during an access, then a stray ack
    issue_a(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 5'd3);
    tick();
    a_req_valid = 1'b0;
    check("rm_mem_req", 64'(a_mem_req), 64'(1'b1));
    rst = 1'b1;
    #1;
    check("rm_mem_req_rst", 64'(a_mem_req), 64'(1'b0));
    check("rm_ready_rst", 64'(a_req_ready), 64'(1'b1));
    check("rm_busy_rst", 64'(a_busy), 64'(1'b0));
    check("rm_be_rst", 64'(a_mem_be), 64'(4'b0000));
    tick();
    rst = 1'b0;
    a_mem_ack = 1'b1;
    a_mem_rdata = 32'hDEAD_BEEF;
    tick();
    a_mem_ack = 1'b0;
    check("rm_late_rsp", 64'(a_rsp_valid), 64'(1'b0));
    check("rm_late_exc", 64'(a_exc_valid), 64'(1'b0));
    tick();
    check("rm_late_rsp2", 64'(a_rsp_valid), 64'(1'b0));
    check("rm_idle_ready", 64'(a_req_ready), 64'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
